// File: rtl/uart_frame_pkg.sv
// Shared encodings for the UART frame controller: FSM states and error codes.
package uart_frame_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ADDR    = 3'd1;
    localparam logic [2:0] LEN     = 3'd2;
    localparam logic [2:0] PAYLOAD = 3'd3;
    localparam logic [2:0] CSUM    = 3'd4;
    localparam logic [2:0] COMMIT  = 3'd5;

    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload holding buffer: synchronous write, combinational read.
module uart_frame_buf #(
    parameter int MAX_LEN = 16,
    localparam int IW = $clog2(MAX_LEN)
) (
    input  logic          i_Clock,
    input  logic          i_We,
    input  logic [IW-1:0] i_Widx,
    input  logic [7:0]    i_Wdata,
    input  logic [IW-1:0] i_Ridx,
    output logic [7:0]    o_Rdata
);

    // No reset: contents are only read after being written by the current frame.
    logic [7:0] mem_q [MAX_LEN];

    always_ff @(posedge i_Clock) begin
        if (i_We) mem_q[i_Widx] <= i_Wdata;
    end

    assign o_Rdata = mem_q[i_Ridx];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Sequences UART bytes into SYNC/ADDR/LEN/payload/CSUM frames and commits
// validated payloads as back-to-back register writes.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 217,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic       i_Clock,
    input  logic       i_Rst,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_Wr_En,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic       o_Frame_Done,
    output logic       o_Frame_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Busy
);

    localparam int IW  = $clog2(MAX_LEN);
    localparam int LW  = IW + 1;
    localparam int TMO = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW  = $clog2(TMO);

    logic [2:0]    state_q, state_d;
    logic [7:0]    base_q, base_d;
    logic [7:0]    sum_q, sum_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          busy_q, busy_d;

    logic          buf_we;
    logic [IW-1:0] rd_idx;
    logic [7:0]    buf_rdata;
    logic [LW-1:0] idx_inc;
    logic [7:0]    sum_chk;
    logic          go_commit;
    logic          err_set;
    logic [1:0]    err_sel;

    uart_frame_buf #(.MAX_LEN(MAX_LEN)) u_buf (
        .i_Clock (i_Clock),
        .i_We    (buf_we),
        .i_Widx  (idx_q[IW-1:0]),
        .i_Wdata (i_RX_Byte),
        .i_Ridx  (rd_idx),
        .o_Rdata (buf_rdata)
    );

    // The first write is issued straight out of CSUM, so COMMIT reads from idx_q.
    assign rd_idx = (state_q == COMMIT) ? idx_q[IW-1:0] : '0;

    always_ff @(posedge i_Clock or posedge i_Rst) begin
        if (i_Rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            sum_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            sum_q      <= sum_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        sum_d     = sum_q;
        len_d     = len_q;
        idx_d     = idx_q;
        tmo_d     = '0;
        buf_we    = 1'b0;
        go_commit = 1'b0;
        err_set   = 1'b0;
        err_sel   = ERR_LEN;
        idx_inc   = idx_q + LW'(1);
        sum_chk   = sum_q + i_RX_Byte;

        case (state_q)
            IDLE: begin
                if (i_RX_DV && i_RX_Byte == SYNC_BYTE) state_d = ADDR;
            end
            ADDR, LEN, PAYLOAD, CSUM: begin
                if (i_RX_DV) begin
                    case (state_q)
                        ADDR: begin
                            base_d  = i_RX_Byte;
                            sum_d   = i_RX_Byte;
                            state_d = LEN;
                        end
                        LEN: begin
                            if (i_RX_Byte == 8'd0 || int'(i_RX_Byte) > MAX_LEN) begin
                                err_set = 1'b1;
                                err_sel = ERR_LEN;
                                state_d = IDLE;
                            end else begin
                                len_d   = i_RX_Byte[LW-1:0];
                                sum_d   = sum_chk;
                                idx_d   = '0;
                                state_d = PAYLOAD;
                            end
                        end
                        PAYLOAD: begin
                            buf_we = 1'b1;
                            sum_d  = sum_chk;
                            idx_d  = idx_inc;
                            if (idx_inc == len_q) state_d = CSUM;
                        end
                        default: begin
                            if (sum_chk == 8'd0) begin
                                go_commit = 1'b1;
                                idx_d     = LW'(1);
                                state_d   = (len_q == LW'(1)) ? IDLE : COMMIT;
                            end else begin
                                err_set = 1'b1;
                                err_sel = ERR_CSUM;
                                state_d = IDLE;
                            end
                        end
                    endcase
                // Counter hits TMO-1 on the same edge the error is registered.
                end else if (tmo_q == TW'(TMO - 2)) begin
                    err_set = 1'b1;
                    err_sel = ERR_TIMEOUT;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            COMMIT: begin
                idx_d = idx_inc;
                if (idx_inc == len_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en_d    = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        done_d     = 1'b0;
        err_d      = err_set;
        err_code_d = err_set ? err_sel : err_code_q;
        busy_d     = (state_d != IDLE);
        if (go_commit || state_q == COMMIT) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_q + 8'(rd_idx);
            wr_data_d = buf_rdata;
            done_d    = (state_d == IDLE);
        end
    end

    assign o_Wr_En      = wr_en_q;
    assign o_Wr_Addr    = wr_addr_q;
    assign o_Wr_Data    = wr_data_q;
    assign o_Frame_Done = done_q;
    assign o_Frame_Err  = err_q;
    assign o_Err_Code   = err_code_q;
    assign o_Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed frame vectors for uart_rx_frame_ctrl plus timeout and reset sequences.
module tb_uart_rx_frame_ctrl;

    localparam int L  = 20 * 217;
    localparam int NV = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv  = 1'b0;
    logic [7:0] rxb = 8'h00;
    logic       wr_en, done, err, busy;
    logic [7:0] wr_addr, wr_data;
    logic [1:0] code;

    uart_rx_frame_ctrl dut (
        .i_Clock      (clk),
        .i_Rst        (rst),
        .i_RX_DV      (dv),
        .i_RX_Byte    (rxb),
        .o_Wr_En      (wr_en),
        .o_Wr_Addr    (wr_addr),
        .o_Wr_Data    (wr_data),
        .o_Frame_Done (done),
        .o_Frame_Err  (err),
        .o_Err_Code   (code),
        .o_Busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_edge = 0;

    logic [15:0] wq[$];
    int          wcyc[$];
    int          dcyc[$];
    int          ecyc[$];
    logic [1:0]  ecode[$];

    typedef struct {
        string        name;
        int           nb;
        logic [159:0] b;
        int           nw;
        logic [255:0] w;
        bit           done;
        bit           err;
        logic [1:0]   code;
    } vec_t;

    vec_t vt[NV];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin wq.push_back({wr_addr, wr_data}); wcyc.push_back(cyc); end
        if (done) dcyc.push_back(cyc);
        if (err) begin ecyc.push_back(cyc); ecode.push_back(code); end
        if (done && err) begin
            total++; bad++;
            $display("FAIL done_err_overlap cycle=%0d both high, required exclusive", cyc);
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic clear_logs();
        wq.delete(); wcyc.delete(); dcyc.delete(); ecyc.delete(); ecode.delete();
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1; dv = 1'b1; rxb = b;
        @(posedge clk); #1; dv = 1'b0;
        last_edge = cyc;
    endtask

    task automatic check_frame(input vec_t v, input int le, input logic [1:0] held);
        logic [15:0] exp_w;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check({v.name, ".wr_count"}, wq.size(), v.nw);
        for (int k = 0; k < v.nw && k < wq.size(); k++) begin
            exp_w = v.w[16*(v.nw-1-k) +: 16];
            check({v.name, ".wr_addr_data"}, wq[k], exp_w);
            check({v.name, ".wr_cycle"}, wcyc[k], le + k);
        end
        check({v.name, ".done_count"}, dcyc.size(), v.done ? 1 : 0);
        if (v.done && dcyc.size() > 0) check({v.name, ".done_cycle"}, dcyc[0], le + v.nw - 1);
        check({v.name, ".err_count"}, ecyc.size(), v.err ? 1 : 0);
        if (v.err && ecyc.size() > 0) begin
            check({v.name, ".err_cycle"}, ecyc[0], le);
            check({v.name, ".err_code_pulse"}, ecode[0], v.code);
        end
        check({v.name, ".err_code_held"}, code, v.err ? v.code : held);
        check({v.name, ".busy_idle"}, busy, 0);
        clear_logs();
    endtask

    initial begin
        logic [1:0] held;
        int         le;

        vt[0] = '{"good",     6, 48'hA5_10_02_11_22_BB, 2, 32'h1011_1122, 1, 0, 2'd0};
        vt[1] = '{"bad_csum", 6, 48'hA5_10_02_11_22_BC, 0, '0,           0, 1, 2'd2};
        vt[2] = '{"len_zero", 3, 24'hA5_10_00,          0, '0,           0, 1, 2'd1};
        vt[3] = '{"len_17",   3, 24'hA5_10_11,          0, '0,           0, 1, 2'd1};
        vt[4] = '{"wrap",     6, 48'hA5_FF_02_AA_BB_9A, 2, 32'hFFAA_00BB, 1, 0, 2'd0};
        vt[5] = '{"garbage",  7, 56'h00_13_A5_10_01_55_9A, 1, 16'h1055, 1, 0, 2'd0};
        vt[6] = '{"sync_data",5, 40'hA5_30_01_A5_2A,    1, 16'h30A5,     1, 0, 2'd0};
        vt[7] = '{"len_max",  20, '0, 16, '0, 1, 0, 2'd0};
        vt[7].b = 24'hA5_20_10;
        for (int k = 0; k < 16; k++) begin
            vt[7].b = {vt[7].b[151:0], 8'(k + 1)};
            vt[7].w = {vt[7].w[239:0], 8'(8'h20 + k), 8'(k + 1)};
        end
        vt[7].b = {vt[7].b[151:0], 8'h48};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.wr_en", wr_en, 0);
        check("reset.done", done, 0);
        check("reset.err", err, 0);
        check("reset.err_code", code, 0);
        check("reset.busy", busy, 0);
        @(posedge clk); #1; rst = 1'b0;
        clear_logs();

        held = 2'd0;
        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < vt[i].nb; k++) send(vt[i].b[8*(vt[i].nb-1-k) +: 8]);
            le = last_edge;
            check_frame(vt[i], le, held);
            if (vt[i].err) held = vt[i].code;
        end

        // Timeout: SYNC, ADDR, then silence.
        send(8'hA5);
        send(8'h10);
        le = last_edge;
        check("timeout.busy_before", busy, 1);
        repeat (L + 5) @(posedge clk);
        @(negedge clk);
        check("timeout.err_count", ecyc.size(), 1);
        if (ecyc.size() > 0) begin
            check("timeout.err_cycle", ecyc[0], le + L - 1);
            check("timeout.err_code_pulse", ecode[0], 3);
        end
        check("timeout.err_code_held", code, 3);
        check("timeout.wr_count", wq.size(), 0);
        check("timeout.busy_after", busy, 0);
        clear_logs();

        // Reset in the middle of the payload.
        send(8'hA5); send(8'h10); send(8'h04); send(8'h01);
        check("rst_mid.busy_before", busy, 1);
        @(posedge clk); #1; rst = 1'b1;
        #1;
        check("rst_mid.busy", busy, 0);
        check("rst_mid.err_code", code, 0);
        check("rst_mid.wr_en", wr_en, 0);
        @(posedge clk); #1; rst = 1'b0;
        clear_logs();
        for (int k = 0; k < vt[0].nb; k++) send(vt[0].b[8*(vt[0].nb-1-k) +: 8]);
        le = last_edge;
        check_frame(vt[0], le, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
